// File: rtl/fetch_line.sv
// Instruction fetch through a single-line buffer refilled by AXI INCR bursts.
// A hit returns the word one cycle after enable. A miss fills the whole line and returns the requested word as it arrives.
module fetch_line #(
  parameter int unsigned ADDR_W     = 29,
  parameter int unsigned LINE_WORDS = 8,
  parameter logic [3:0]  AXI_ID     = 4'd0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic [31:0]       pc,
  input  logic              flush,
  output logic              pcread,
  output logic              done,
  output logic              err,
  output logic [31:0]       command,
  output logic [ADDR_W-1:0] araddr,
  output logic [1:0]        arburst,
  output logic [3:0]        arcache,
  output logic [3:0]        arid,
  output logic [7:0]        arlen,
  output logic              arlock,
  output logic [2:0]        arprot,
  output logic [3:0]        arqos,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [3:0]        rid,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);
  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned LO_W  = OFF_W + 2;
  localparam int unsigned TAG_W = ADDR_W - LO_W;
  localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state_q;
  logic              valid_q, errbit_q, got_q, flushed_q;
  logic [TAG_W-1:0]  tag_q;
  logic [OFF_W-1:0]  off_q, cnt_q;
  logic [31:0]       line_q [LINE_WORDS];
  logic              done_q, pcread_q, err_q, arvalid_q, rready_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [31:0]       command_q;

  logic [TAG_W-1:0]  pc_tag;
  logic [OFF_W-1:0]  pc_off;
  logic              hit, beat, beat_err, errbit_d, flushed_d;
  logic              unused_ok;

  assign pc_tag    = pc[ADDR_W-1:LO_W];
  assign pc_off    = pc[LO_W-1:2];
  // A flush in the same cycle as the request forces a refill.
  assign hit       = valid_q && (tag_q == pc_tag) && !flush;
  assign beat      = rvalid && rready_q;
  assign beat_err  = (rresp != 2'b00);
  assign errbit_d  = errbit_q | beat_err;
  assign flushed_d = flushed_q | flush;
  assign unused_ok = ^{rid, pc};

  assign arburst = 2'b01;
  assign arcache = 4'b0011;
  assign arid    = AXI_ID;
  assign arlen   = 8'(LINE_WORDS - 1);
  assign arlock  = 1'b0;
  assign arprot  = 3'b000;
  assign arqos   = 4'b0000;
  assign arsize  = 3'b010;

  assign pcread  = pcread_q;
  assign done    = done_q;
  assign err     = err_q;
  assign command = command_q;
  assign araddr  = araddr_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      errbit_q  <= 1'b0;
      got_q     <= 1'b0;
      flushed_q <= 1'b0;
      tag_q     <= '0;
      off_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      pcread_q  <= 1'b0;
      err_q     <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      araddr_q  <= '0;
      command_q <= '0;
    end else begin
      done_q   <= 1'b0;
      pcread_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flush) valid_q <= 1'b0;
          if (enable) begin
            pcread_q <= 1'b1;
            if (hit) begin
              done_q    <= 1'b1;
              command_q <= line_q[pc_off];
            end else begin
              state_q   <= ADDR;
              arvalid_q <= 1'b1;
              araddr_q  <= {pc_tag, {LO_W{1'b0}}};
              tag_q     <= pc_tag;
              off_q     <= pc_off;
              valid_q   <= 1'b0;
              errbit_q  <= 1'b0;
              got_q     <= 1'b0;
              flushed_q <= 1'b0;
            end
          end
        end
        ADDR: begin
          if (flush) flushed_q <= 1'b1;
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            cnt_q     <= '0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (flush) flushed_q <= 1'b1;
          if (beat) begin
            line_q[cnt_q] <= rdata;
            if (cnt_q != LAST) cnt_q <= cnt_q + OFF_W'(1);
            if (beat_err) errbit_q <= 1'b1;
            if (!got_q && cnt_q == off_q) begin
              done_q    <= 1'b1;
              err_q     <= beat_err;
              command_q <= rdata;
              got_q     <= 1'b1;
            end
            if (rlast) begin
              rready_q <= 1'b0;
              state_q  <= IDLE;
              // Only a complete, clean, unflushed burst leaves a usable line.
              valid_q  <= !errbit_d && !flushed_d && (cnt_q == LAST);
              if (!got_q && cnt_q != off_q) begin
                done_q    <= 1'b1;
                err_q     <= 1'b1;
                command_q <= '0;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_line.sv
// Directed bench for fetch_line: stimulus pushes expected (command, err) into a queue, a monitor pops on each done.
module tb_fetch_line;
  logic        clk = 1'b0;
  logic        rstn, enable, flush, arready, rvalid, rlast;
  logic [31:0] pc, rdata;
  logic [3:0]  rid;
  logic [1:0]  rresp;
  logic        pcread, done, err, arvalid, rready, arlock;
  logic [31:0] command;
  logic [28:0] araddr;
  logic [1:0]  arburst;
  logic [3:0]  arcache, arid, arqos;
  logic [7:0]  arlen;
  logic [2:0]  arprot, arsize;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] cmd;
    logic        er;
  } exp_t;
  exp_t q[$];

  fetch_line #(.ADDR_W(29), .LINE_WORDS(8), .AXI_ID(4'd0)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .pc(pc), .flush(flush),
    .pcread(pcread), .done(done), .err(err), .command(command),
    .araddr(araddr), .arburst(arburst), .arcache(arcache), .arid(arid),
    .arlen(arlen), .arlock(arlock), .arprot(arprot), .arqos(arqos),
    .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always begin
    @(posedge clk);
    #2;
    if (rstn && done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sb_command", command, e.cmd);
        check("sb_err", 32'(err), 32'(e.er));
      end
    end
  end

  task automatic hit(input logic [31:0] pcv, input logic [31:0] cmd);
    enable = 1'b1;
    pc     = pcv;
    q.push_back('{cmd: cmd, er: 1'b0});
    tick();
    enable = 1'b0;
    check("hit_pcread", 32'(pcread), 32'd1);
    check("hit_done", 32'(done), 32'd1);
    check("hit_arvalid", 32'(arvalid), 32'd0);
  endtask

  // errb / flb < 0 disable the error and flush beats.
  task automatic miss(input logic [31:0] pcv, input logic [31:0] base, input int errb,
                      input int flb, input int arwait, input int nbeats, input bit fl_req);
    int          off;
    logic [31:0] exp_addr;
    off      = int'(pcv[4:2]);
    exp_addr = pcv & 32'h1FFF_FFE0;
    enable   = 1'b1;
    pc       = pcv;
    flush    = fl_req;
    tick();
    enable = 1'b0;
    flush  = 1'b0;
    check("miss_pcread", 32'(pcread), 32'd1);
    check("miss_arvalid", 32'(arvalid), 32'd1);
    check("miss_araddr", 32'(araddr), exp_addr);
    check("miss_arlen", 32'(arlen), 32'd7);
    for (int w = 0; w < arwait; w++) begin
      enable = 1'b1;
      tick();
      check("wait_arvalid", 32'(arvalid), 32'd1);
      check("wait_araddr", 32'(araddr), exp_addr);
      check("wait_no_pcread", 32'(pcread), 32'd0);
    end
    enable  = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check("ar_done_arvalid", 32'(arvalid), 32'd0);
    check("ar_done_rready", 32'(rready), 32'd1);
    for (int i = 0; i < nbeats; i++) begin
      rvalid = 1'b1;
      rdata  = base + 32'(i);
      rresp  = (i == errb) ? 2'b10 : 2'b00;
      rlast  = (i == nbeats - 1);
      flush  = (i == flb);
      if (i == off) q.push_back('{cmd: base + 32'(i), er: (errb == off)});
      else if (i == nbeats - 1 && off >= nbeats) q.push_back('{cmd: 32'd0, er: 1'b1});
      tick();
      flush = 1'b0;
      if (i == off) check("miss_done_latency", 32'(done), 32'd1);
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    check("burst_end_rready", 32'(rready), 32'd0);
  endtask

  initial begin
    rstn = 1'b0; enable = 1'b0; flush = 1'b0; arready = 1'b0; rvalid = 1'b0;
    rlast = 1'b0; pc = '0; rdata = '0; rid = 4'd3; rresp = 2'b00;
    repeat (3) tick();
    check("rst_done", 32'(done), 32'd0);
    check("rst_pcread", 32'(pcread), 32'd0);
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_araddr", 32'(araddr), 32'd0);
    check("rst_command", command, 32'd0);
    check("rst_arburst", 32'(arburst), 32'd1);
    check("rst_arsize", 32'(arsize), 32'd2);
    check("rst_arcache", 32'(arcache), 32'd3);
    check("rst_arid", 32'(arid), 32'd0);
    rstn = 1'b1;
    tick();

    miss(32'h104, 32'hA0, -1, -1, 0, 8, 1'b0);
    hit(32'h11C, 32'hA7);
    hit(32'h100, 32'hA0);

    miss(32'h200, 32'hB0, -1, -1, 5, 8, 1'b0);
    hit(32'h21C, 32'hB7);

    miss(32'h10C, 32'hC0, 3, -1, 0, 8, 1'b0);
    miss(32'h100, 32'hD0, -1, -1, 0, 8, 1'b0);

    miss(32'h30C, 32'hE0, -1, 2, 0, 8, 1'b0);
    miss(32'h300, 32'hF0, -1, -1, 0, 8, 1'b0);
    hit(32'h304, 32'hF1);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    miss(32'h318, 32'h20, -1, -1, 0, 3, 1'b0);
    miss(32'h300, 32'h30, -1, -1, 0, 8, 1'b0);
    miss(32'h304, 32'h40, -1, -1, 0, 8, 1'b1);
    hit(32'h308, 32'h42);

    enable = 1'b1;
    pc     = 32'h414;
    tick();
    enable  = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = 32'h55;
    tick();
    rdata = 32'h56;
    tick();
    rstn = 1'b0;
    tick();
    check("midrst_rready", 32'(rready), 32'd0);
    check("midrst_arvalid", 32'(arvalid), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    rvalid = 1'b0;
    rstn   = 1'b1;
    tick();
    miss(32'h414, 32'h60, -1, -1, 0, 8, 1'b0);
    hit(32'h41C, 32'h67);

    repeat (4) tick();
    check("sb_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
